// File: rtl/vga_fb_pkg.sv
// Shared types and default sizes for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    typedef enum logic [0:0] {
        FB_IDLE,
        FB_FETCH
    } fb_state_e;

    localparam int unsigned FB_ADDR_W_DEF = 17;
    localparam int unsigned FB_DATA_W_DEF = 8;
    localparam int unsigned FB_BURST_DEF  = 16;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: line prefetch bursts take absolute priority.
// The pixel-draw writer only gets the SRAM when no fetch is running or queued.
// A single pending slot absorbs a line request that arrives mid-burst.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = FB_ADDR_W_DEF,
    parameter int unsigned DATA_W    = FB_DATA_W_DEF,
    parameter int unsigned BURST_LEN = FB_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_line_req,
    input  logic [ADDR_W-1:0] i_line_base,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_line_done,
    output logic              o_overrun,
    input  logic              i_ovr_clr,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned      CNT_W      = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(BURST_LEN - 1);

    fb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_base_q, pend_base_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pv_q;
    logic              done_q;
    logic              ovr_q;
    logic              ovr_set;
    logic              boundary;
    logic              start;
    logic [ADDR_W-1:0] start_base;

    // Writer may only proceed when the SRAM is free now and nothing is queued.
    assign o_wr_ready = (state_q == FB_IDLE) & ~pend_q & ~i_line_req;

    // Next-state and next bus command; fetch requests always outrank the writer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        last_d      = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ovr_set     = 1'b0;
        start       = 1'b0;
        start_base  = pend_base_q;
        boundary    = (state_q == FB_IDLE) || (cnt_q == BURST_CNT);

        if (boundary) begin
            // Burst finished (or idle): chain the queued fetch first, then a new request.
            if (pend_q) begin
                start       = 1'b1;
                start_base  = pend_base_q;
                pend_d      = i_line_req;
                if (i_line_req) begin
                    pend_base_d = i_line_base;
                end
            end else if (i_line_req) begin
                start      = 1'b1;
                start_base = i_line_base;
            end else begin
                state_d = FB_IDLE;
                if (o_wr_ready && i_wr_valid) begin
                    we_d    = 1'b1;
                    addr_d  = i_wr_addr;
                    wdata_d = i_wr_data;
                end
            end
        end else begin
            // Mid-burst: next consecutive read; a new request queues or is lost.
            re_d   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            last_d = (cnt_q == LAST_ISSUE);
            if (i_line_req) begin
                if (pend_q) begin
                    ovr_set = 1'b1;
                end else begin
                    pend_d      = 1'b1;
                    pend_base_d = i_line_base;
                end
            end
        end

        if (start) begin
            state_d = FB_FETCH;
            re_d    = 1'b1;
            addr_d  = start_base;
            cnt_d   = CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst counter, pending slot and registered SRAM command.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_base_q <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_base_q <= pend_base_d;
            re_q        <= re_d;
            we_q        <= we_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Read-return pipe: data arrives one cycle after the strobe, done rides with the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pv_q   <= re_q;
            done_q <= re_q & last_q;
        end
    end

    // Sticky overrun flag; a new loss wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (i_ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign o_mem_re    = re_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_pix_valid = pv_q;
    assign o_line_done = done_q;
    assign o_overrun   = ovr_q;
    // The SRAM output register already holds the word; qualify it with the strobe.
    assign o_pix_data  = pv_q ? i_mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: transaction-level timing model plus literal spot checks.
module tb_vga_fb_arbiter;

    localparam int unsigned AW   = 17;
    localparam int unsigned DW   = 8;
    localparam int unsigned BL   = 16;
    localparam int          NCYC = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_line_req = 1'b0;
    logic [AW-1:0] i_line_base = '0;
    logic          o_pix_valid;
    logic [DW-1:0] o_pix_data;
    logic          o_line_done;
    logic          o_overrun;
    logic          i_ovr_clr = 1'b0;
    logic          i_wr_valid = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          o_wr_ready;
    logic          o_mem_re;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_line_req(i_line_req), .i_line_base(i_line_base),
        .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data),
        .o_line_done(o_line_done), .o_overrun(o_overrun), .i_ovr_clr(i_ovr_clr),
        .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready),
        .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    // SRAM content pattern: low address byte * 3 + 0x11.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return 8'(a[7:0] * 8'd3 + 8'h11);
    endfunction

    // Synchronous-read SRAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (o_mem_re) i_mem_rdata <= pattern(o_mem_addr);
    end

    // Expected-output timeline, indexed by cycle.
    bit            chk     [NCYC];
    bit            chk_rdy [NCYC];
    bit            exp_rdy [NCYC];
    bit            exp_re  [NCYC];
    bit            exp_we  [NCYC];
    bit            exp_pv  [NCYC];
    bit            exp_done[NCYC];
    bit            exp_ovr [NCYC];
    bit            hold_clr[NCYC];
    logic [AW-1:0] exp_maddr [NCYC];
    logic [AW-1:0] exp_pdaddr[NCYC];
    logic [DW-1:0] exp_wdata [NCYC];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        int            c;
        int            sel;
        logic [AW-1:0] val;
        string         nm;
    } lit_t;
    lit_t lits[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int busy_until = -100;
    int last_start = -100;
    bit ovr_m = 1'b0;

    // Model: a fetch starts the cycle after its request or right after the previous
    // burst; a request is lost when a fetch is already scheduled beyond next cycle.
    task automatic model_step(input int c);
        bit            ovr_set;
        int            s;
        logic [AW-1:0] a;
        ovr_set = 1'b0;
        chk[c+1] = 1'b1;
        if (rst) begin
            for (int k = c + 1; k < NCYC; k++) begin
                exp_re[k] = 1'b0; exp_we[k] = 1'b0; exp_pv[k] = 1'b0; exp_done[k] = 1'b0;
            end
            busy_until = -100;
            last_start = -100;
            ovr_m = 1'b0;
            hold_clr[c+1] = 1'b1;
            exp_ovr[c+1] = 1'b0;
            chk_rdy[c] = 1'b0;
            return;
        end
        chk_rdy[c] = 1'b1;
        exp_rdy[c] = (c > busy_until) && !i_line_req;
        if (i_line_req) begin
            if (last_start > c + 1) begin
                ovr_set = 1'b1;
            end else begin
                s = (c + 1 > busy_until + 1) ? c + 1 : busy_until + 1;
                for (int k = 0; k < int'(BL); k++) begin
                    a = AW'(i_line_base + AW'(k));
                    exp_re[s+k] = 1'b1;
                    exp_maddr[s+k] = a;
                    exp_pv[s+k+1] = 1'b1;
                    exp_pdaddr[s+k+1] = a;
                end
                exp_done[s+int'(BL)] = 1'b1;
                busy_until = s + int'(BL) - 1;
                last_start = s;
            end
        end
        if (i_wr_valid && exp_rdy[c]) begin
            exp_we[c+1] = 1'b1;
            exp_maddr[c+1] = i_wr_addr;
            exp_wdata[c+1] = i_wr_data;
            void'(wq.pop_front());
        end
        if (ovr_set) ovr_m = 1'b1;
        else if (i_ovr_clr) ovr_m = 1'b0;
        exp_ovr[c+1] = ovr_m;
    endtask

    function automatic logic [AW-1:0] out_sel(input int sel);
        case (sel)
            0: return AW'(o_mem_re);
            1: return AW'(o_mem_we);
            2: return AW'(o_pix_valid);
            3: return AW'(o_line_done);
            4: return AW'(o_overrun);
            5: return o_mem_addr;
            6: return AW'(o_wr_ready);
            7: return AW'(o_pix_data);
            default: return AW'(o_mem_wdata);
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, want);
        end
    endtask

    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wd = '0;

    // Single compare process, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (cyc < NCYC && chk[cyc]) begin
            if (hold_clr[cyc]) begin
                h_addr = '0;
                h_wd = '0;
            end
            if (exp_re[cyc] || exp_we[cyc]) h_addr = exp_maddr[cyc];
            if (exp_we[cyc]) h_wd = exp_wdata[cyc];
            cmp("mem_re", AW'(o_mem_re), AW'(exp_re[cyc]));
            cmp("mem_we", AW'(o_mem_we), AW'(exp_we[cyc]));
            cmp("re_we_exclusive", AW'(o_mem_re & o_mem_we), '0);
            cmp("mem_addr", o_mem_addr, h_addr);
            cmp("mem_wdata", AW'(o_mem_wdata), AW'(h_wd));
            cmp("pix_valid", AW'(o_pix_valid), AW'(exp_pv[cyc]));
            cmp("line_done", AW'(o_line_done), AW'(exp_done[cyc]));
            cmp("overrun", AW'(o_overrun), AW'(exp_ovr[cyc]));
            if (exp_pv[cyc]) cmp("pix_data", AW'(o_pix_data), AW'(pattern(exp_pdaddr[cyc])));
            if (chk_rdy[cyc]) cmp("wr_ready", AW'(o_wr_ready), AW'(exp_rdy[cyc]));
        end
        foreach (lits[i]) begin
            if (lits[i].c == cyc) cmp(lits[i].nm, out_sel(lits[i].sel), lits[i].val);
        end
    end

    task automatic lit(input int c, input int sel, input logic [AW-1:0] v, input string nm);
        lits.push_back('{c, sel, v, nm});
    endtask

    // Apply one cycle of stimulus, update the model, advance to the next cycle.
    task automatic tick(input logic lr, input logic [AW-1:0] base, input logic clr, input logic rs);
        rst = rs;
        i_line_req = lr;
        i_line_base = base;
        i_ovr_clr = clr;
        if (!rs && wq.size() > 0) begin
            i_wr_valid = 1'b1;
            i_wr_addr = wq[0].a;
            i_wr_data = wq[0].d;
        end else begin
            i_wr_valid = 1'b0;
        end
        model_step(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    int t;

    initial begin
        @(posedge clk);
        #1;
        cyc = 0;

        // Reset held 3 cycles, then quiet bus.
        repeat (3) tick(1'b0, '0, 1'b0, 1'b1);
        t = cyc;
        lit(t, 0, '0, "lit_reset_re");
        lit(t, 1, '0, "lit_reset_we");
        lit(t, 2, '0, "lit_reset_pv");
        lit(t, 3, '0, "lit_reset_done");
        lit(t, 4, '0, "lit_reset_ovr");
        lit(t, 5, '0, "lit_reset_addr");
        lit(t, 7, '0, "lit_reset_pixdata");
        lit(t, 8, '0, "lit_reset_wdata");
        lit(t, 6, 17'd1, "lit_reset_ready");
        idle(3);

        // Plain burst at 0x00010.
        t = cyc;
        lit(t + 1, 0, 17'd1, "lit_b1_first_re");
        lit(t + 1, 5, 17'h00010, "lit_b1_first_addr");
        lit(t + 2, 2, 17'd1, "lit_b1_first_pv");
        lit(t + 2, 7, 17'h41, "lit_b1_first_data");
        lit(t + 16, 5, 17'h0001F, "lit_b1_last_addr");
        lit(t + 17, 3, 17'd1, "lit_b1_done");
        lit(t + 17, 7, 17'h6E, "lit_b1_last_data");
        lit(t + 17, 0, '0, "lit_b1_re_off");
        tick(1'b1, 17'h00010, 1'b0, 1'b0);
        idle(20);

        // Burst wrapping at the top of the address space.
        t = cyc;
        lit(t + 2, 7, 17'hF9, "lit_wrap_first_data");
        lit(t + 8, 5, 17'h1FFFF, "lit_wrap_top");
        lit(t + 9, 5, 17'h00000, "lit_wrap_zero");
        lit(t + 16, 5, 17'h00007, "lit_wrap_last");
        tick(1'b1, 17'h1FFF8, 1'b0, 1'b0);
        idle(20);

        // Writer stream interrupted by a line request.
        for (int i = 0; i < 8; i++) wq.push_back('{AW'(17'h08000 + i), DW'(8'hC0 + i)});
        t = cyc;
        lit(t + 1, 1, 17'd1, "lit_wr0_we");
        lit(t + 1, 5, 17'h08000, "lit_wr0_addr");
        lit(t + 2, 1, 17'd1, "lit_wr1_inflight");
        lit(t + 2, 5, 17'h08001, "lit_wr1_addr");
        lit(t + 2, 6, '0, "lit_ready_drop");
        lit(t + 3, 0, 17'd1, "lit_fetch_after_wr");
        lit(t + 3, 5, 17'h00100, "lit_fetch_addr");
        lit(t + 19, 3, 17'd1, "lit_mix_done");
        lit(t + 20, 1, 17'd1, "lit_wr2_resume");
        lit(t + 20, 5, 17'h08002, "lit_wr2_addr");
        idle(2);
        tick(1'b1, 17'h00100, 1'b0, 1'b0);
        idle(30);

        // Three requests: second chains back-to-back, third overruns.
        t = cyc;
        lit(t + 5, 4, 17'd1, "lit_ovr_set");
        lit(t + 16, 5, 17'h0020F, "lit_chain_a_last");
        lit(t + 17, 0, 17'd1, "lit_chain_b_re");
        lit(t + 17, 5, 17'h00300, "lit_chain_b_first");
        lit(t + 32, 5, 17'h0030F, "lit_chain_b_last");
        lit(t + 33, 3, 17'd1, "lit_chain_b_done");
        lit(t + 33, 0, '0, "lit_chain_end");
        lit(t + 40, 4, 17'd1, "lit_ovr_sticky");
        lit(t + 41, 4, '0, "lit_ovr_cleared");
        tick(1'b1, 17'h00200, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 17'h00300, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 17'h00400, 1'b0, 1'b0);
        idle(35);
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(3);

        // Reset mid-fetch, then a clean fetch.
        t = cyc;
        lit(t + 5, 0, 17'd1, "lit_abort_re_before");
        lit(t + 6, 0, '0, "lit_abort_re_after");
        lit(t + 6, 2, '0, "lit_abort_pv_after");
        lit(t + 17, 3, '0, "lit_abort_no_done");
        tick(1'b1, 17'h00500, 1'b0, 1'b0);
        idle(4);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle(20);
        t = cyc;
        lit(t + 1, 5, 17'h00600, "lit_post_first");
        lit(t + 16, 5, 17'h0060F, "lit_post_last");
        lit(t + 17, 3, 17'd1, "lit_post_done");
        tick(1'b1, 17'h00600, 1'b0, 1'b0);
        idle(20);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
